// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_adaptor
// Function : Splits cache-line reads/writes into BURST_W beats to memory.
// Revision : 1.0 - initial release
// ============================================================================
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        address_i,
  input  logic [LINE_W-1:0]  line_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o
);

  localparam int C_BEATS = LINE_W / BURST_W;
  localparam int C_CNT_W = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(C_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [C_CNT_W-1:0]  r_cnt;
  logic [31:0]         r_addr;
  logic [LINE_W-1:0]   r_rline;
  logic [LINE_W-1:0]   r_wline;
  logic                w_beat;
  logic                w_last;
  logic                w_accept;

  assign w_beat   = resp_i && ((r_state == READ) || (r_state == WRITE));
  assign w_last   = w_beat && (r_cnt == C_LAST);
  assign w_accept = (r_state == IDLE) && (read_i || write_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (write_i)     w_next = WRITE;
        else if (read_i) w_next = READ;
      end
      READ, WRITE: begin
        if (w_last) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Separate read/write buffers keep line_o stable across intervening writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rline <= '0;
      r_wline <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_cnt <= '0;
      end else if (w_beat) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_addr <= {address_i[31:5], 5'b0};
      end
      if ((r_state == IDLE) && write_i) begin
        r_wline <= line_i;
      end
      if ((r_state == READ) && resp_i) begin
        r_rline[r_cnt*BURST_W +: BURST_W] <= burst_i;
      end
    end
  end

  assign read_o    = (r_state == READ);
  assign write_o   = (r_state == WRITE);
  assign resp_o    = (r_state == DONE);
  assign address_o = r_addr;
  assign line_o    = r_rline;
  assign burst_o   = r_wline[r_cnt*BURST_W +: BURST_W];

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cacheline_adaptor
// Function : Directed self-checking bench for cacheline_adaptor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cacheline_adaptor;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;

  logic               clk;
  logic               rst;
  logic [31:0]        address_i;
  logic [LINE_W-1:0]  line_i;
  logic               read_i;
  logic               write_i;
  logic [LINE_W-1:0]  line_o;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic               resp_i;
  logic [BURST_W-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;

  cacheline_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W)) dut (
    .clk(clk), .rst(rst),
    .address_i(address_i), .line_i(line_i), .read_i(read_i), .write_i(write_i),
    .line_o(line_o), .resp_o(resp_o),
    .burst_i(burst_i), .resp_i(resp_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cycles = 0;
  int wr_cycles = 0;
  int resp_cnt  = 0;
  logic [BURST_W-1:0] wq[$];
  logic [BURST_W-1:0] rbeat[4];

  always @(negedge clk) begin
    if (read_o)  rd_cycles++;
    if (write_o) wr_cycles++;
    if (resp_o)  resp_cnt++;
    if (write_o && resp_i) wq.push_back(burst_o);
  end

  task automatic check_val(input string tag, input logic [LINE_W-1:0] act,
                           input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // pat bit i = resp_i in cycle i; read beats taken in order from rbeat.
  task automatic run_beats(input logic [15:0] pat, input int n);
    int k = 0;
    for (int i = 0; i < n; i++) begin
      resp_i  = pat[i];
      burst_i = pat[i] ? rbeat[k] : '0;
      if (pat[i]) k++;
      @(posedge clk); #1;
    end
    resp_i  = 1'b0;
    burst_i = '0;
  endtask

  task automatic request(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [LINE_W-1:0] l);
    read_i = rd; write_i = wr; address_i = a; line_i = l;
    @(posedge clk); #1;
    read_i = 1'b0; write_i = 1'b0;
  endtask

  localparam logic [BURST_W-1:0] B1 = {16{4'h1}};
  localparam logic [BURST_W-1:0] B2 = {16{4'h2}};
  localparam logic [BURST_W-1:0] B3 = {16{4'h3}};
  localparam logic [BURST_W-1:0] B4 = {16{4'h4}};
  localparam logic [BURST_W-1:0] BA = {16{4'hA}};
  localparam logic [BURST_W-1:0] BB = {16{4'hB}};
  localparam logic [BURST_W-1:0] BC = {16{4'hC}};
  localparam logic [BURST_W-1:0] BD = {16{4'hD}};

  int r0, w0, p0;
  logic [LINE_W-1:0] line_a;
  logic [LINE_W-1:0] line_b;
  logic [LINE_W-1:0] wl;
  logic [LINE_W-1:0] wl2;

  initial begin
    rst = 1'b0; address_i = '0; line_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    line_a = {B4, B3, B2, B1};
    line_b = {B1, B2, B3, B4};
    wl  = {BD, BC, BB, BA};
    wl2 = {BA, BB, BC, BD};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_read_o",  read_o,    0);
    check_val("rst_write_o", write_o,   0);
    check_val("rst_resp_o",  resp_o,    0);
    check_val("rst_addr",    address_o, 0);
    check_val("rst_burst",   burst_o,   0);
    check_val("rst_line",    line_o,    0);

    // Basic read; request presented on the first edge with reset released
    @(posedge clk); #1;
    rst = 1'b1;
    r0 = rd_cycles; p0 = resp_cnt;
    rbeat[0] = B1; rbeat[1] = B2; rbeat[2] = B3; rbeat[3] = B4;
    request(1'b1, 1'b0, 32'h0000_1234, '0);
    check_val("rd_read_o_on", read_o, 1);
    check_val("rd_addr", address_o, 32'h0000_1220);
    run_beats(16'h000F, 4);
    check_val("rd_resp_done", resp_o, 1);
    check_val("rd_read_o_off", read_o, 0);
    check_val("rd_line", line_o, line_a);
    @(posedge clk); #1;
    check_val("rd_resp_one_cycle", resp_o, 0);
    repeat (2) @(posedge clk); #1;
    check_val("rd_read_cycles", rd_cycles - r0, 4);
    check_val("rd_resp_count", resp_cnt - p0, 1);

    // Gapped read: 1,0,0,1,1,0,1
    r0 = rd_cycles; p0 = resp_cnt;
    rbeat[0] = B4; rbeat[1] = B3; rbeat[2] = B2; rbeat[3] = B1;
    request(1'b1, 1'b0, 32'hFFFF_FFFF, '0);
    check_val("gap_addr", address_o, 32'hFFFF_FFE0);
    run_beats(16'h0059, 7);
    check_val("gap_resp_done", resp_o, 1);
    check_val("gap_line", line_o, line_b);
    repeat (2) @(posedge clk); #1;
    check_val("gap_read_cycles", rd_cycles - r0, 7);
    check_val("gap_resp_count", resp_cnt - p0, 1);

    // resp_i in IDLE is ignored
    r0 = rd_cycles; w0 = wr_cycles; p0 = resp_cnt;
    rbeat[0] = '1; rbeat[1] = '1; rbeat[2] = '1; rbeat[3] = '1;
    run_beats(16'h0007, 3);
    repeat (2) @(posedge clk); #1;
    check_val("idle_line_kept", line_o, line_b);
    check_val("idle_no_bus", (rd_cycles - r0) + (wr_cycles - w0), 0);
    check_val("idle_no_resp", resp_cnt - p0, 0);

    // Write
    wq.delete();
    r0 = rd_cycles; w0 = wr_cycles; p0 = resp_cnt;
    request(1'b0, 1'b1, 32'h8000_003F, wl);
    check_val("wr_write_o_on", write_o, 1);
    check_val("wr_addr", address_o, 32'h8000_0020);
    run_beats(16'h000F, 4);
    check_val("wr_resp_done", resp_o, 1);
    check_val("wr_write_o_off", write_o, 0);
    repeat (2) @(posedge clk); #1;
    check_val("wr_beat_count", wq.size(), 4);
    if (wq.size() == 4) begin
      check_val("wr_beat0", wq[0], BA);
      check_val("wr_beat1", wq[1], BB);
      check_val("wr_beat2", wq[2], BC);
      check_val("wr_beat3", wq[3], BD);
    end
    check_val("wr_write_cycles", wr_cycles - w0, 4);
    check_val("wr_resp_count", resp_cnt - p0, 1);
    check_val("wr_no_read", rd_cycles - r0, 0);
    check_val("wr_line_o_kept", line_o, line_b);

    // Simultaneous read+write: write wins; read re-pulsed in WRITE is ignored
    wq.delete();
    r0 = rd_cycles; w0 = wr_cycles; p0 = resp_cnt;
    request(1'b1, 1'b1, 32'h0000_ABCD, wl2);
    check_val("prio_write_o", write_o, 1);
    check_val("prio_read_o", read_o, 0);
    request(1'b1, 1'b0, 32'h1111_1111, '0);
    check_val("prio_addr_held", address_o, 32'h0000_ABC0);
    run_beats(16'h000F, 4);
    repeat (3) @(posedge clk); #1;
    check_val("prio_no_read", rd_cycles - r0, 0);
    check_val("prio_write_cycles", wr_cycles - w0, 5);
    check_val("prio_resp_count", resp_cnt - p0, 1);
    if (wq.size() == 4) begin
      check_val("prio_beat0", wq[0], BD);
      check_val("prio_beat3", wq[3], BA);
    end else begin
      check_val("prio_beat_count", wq.size(), 4);
    end

    // Reset between beats 2 and 3 of a read
    p0 = resp_cnt;
    rbeat[0] = B2; rbeat[1] = B2;
    request(1'b1, 1'b0, 32'h0000_4000, '0);
    run_beats(16'h0003, 2);
    resp_i = 1'b1; burst_i = B3;
    #2;
    rst = 1'b0;
    #1;
    check_val("mrst_read_o", read_o, 0);
    check_val("mrst_addr", address_o, 0);
    check_val("mrst_line", line_o, 0);
    check_val("mrst_resp_o", resp_o, 0);
    repeat (2) @(posedge clk); #1;
    resp_i = 1'b0; burst_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_val("mrst_no_resp", resp_cnt - p0, 0);
    rbeat[0] = B1; rbeat[1] = B2; rbeat[2] = B3; rbeat[3] = B4;
    request(1'b1, 1'b0, 32'h0000_5055, '0);
    check_val("post_addr", address_o, 32'h0000_5040);
    run_beats(16'h000F, 4);
    check_val("post_resp", resp_o, 1);
    check_val("post_line", line_o, line_a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameter: LINE_W, default 256, cache line width in bits.
REQ-002 Parameter: BURST_W, default 64, physical memory beat width in bits; BEATS = LINE_W/BURST_W (default 4).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; the block is held in reset while rst=0.
REQ-005 address_i  input  32  line address from arbiter (pmem_address_m side).
REQ-006 line_i  input  LINE_W  write line from arbiter.
REQ-007 read_i  input  1  line read request from arbiter.
REQ-008 write_i  input  1  line write request from arbiter.
REQ-009 line_o  output  LINE_W  assembled read line to arbiter.
REQ-010 resp_o  output  1  line transaction complete, to arbiter.
REQ-011 burst_i  input  BURST_W  read beat from physical memory.
REQ-012 resp_i  input  1  memory beat-valid/acknowledge.
REQ-013 burst_o  output  BURST_W  write beat to physical memory.
REQ-014 address_o  output  32  line-aligned address to physical memory.
REQ-015 read_o  output  1  burst read request to memory.
REQ-016 write_o  output  1  burst write request to memory.

Function
REQ-017 States SHALL be IDLE, READ, WRITE, DONE; 2-bit beat counter cnt (0..BEATS-1).
REQ-018 In IDLE, a request SHALL be sampled on one cycle only: address_i latched with bits [4:0] forced to 0, and line_i latched if write_i=1; the arbiter drops its request after one cycle, so no hold by the requester is required.
REQ-019 IDLE with write_i=1 -> WRITE, cnt=0; else read_i=1 -> READ, cnt=0; write_i and read_i together -> write priority, read_i ignored.
REQ-020 read_o SHALL be 1 exactly while in READ; write_o exactly while in WRITE; address_o SHALL be the latched address, stable throughout.
REQ-021 READ: each cycle with resp_i=1, burst_i SHALL be stored into line bits [cnt*BURST_W +: BURST_W] and cnt incremented; beats are little-endian (beat 0 = bits 63:0).
REQ-022 WRITE: burst_o SHALL equal latched line[cnt*BURST_W +: BURST_W]; cnt advances on each resp_i=1.
REQ-023 resp_i gaps (resp_i=0 between beats) SHALL stall cnt with no data loss; no timeout.
REQ-024 On resp_i=1 with cnt=BEATS-1, cnt SHALL wrap to 0 and the state SHALL go to DONE; read_o/write_o deassert in the following cycle.
REQ-025 DONE SHALL assert resp_o=1 for exactly one cycle, then return to IDLE; resp_o=0 in all other states.
REQ-026 line_o SHALL present the assembled buffer continuously; valid at least in the DONE cycle, and held unchanged until the next READ's first beat.
REQ-027 read_i/write_i in READ, WRITE or DONE SHALL be ignored (not queued).
REQ-028 resp_i in IDLE or DONE SHALL be ignored.
REQ-029 Transaction latency SHALL be: request cycle -> READ/WRITE next edge; resp_o = 1 cycle after the edge capturing the last beat; min total BEATS+2 cycles.

Reset
REQ-030 rst=0 SHALL immediately, without waiting for clk, force state=IDLE, cnt=0, read_o=0, write_o=0, resp_o=0, address_o=0, burst_o=0, line buffer=0.
REQ-031 Reset mid-burst SHALL abandon the transaction; no resp_o pulse follows release.
REQ-032 The first request SHALL be accepted on the first rising edge with rst=1.

Verification
REQ-033 Read: address_i=0x0000_1234, read_i pulse 1 cycle; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles -> address_o=0x0000_1220, read_o 4 cycles, line_o=0x44..44_33..33_22..22_11..11, resp_o one cycle.
REQ-034 Write: line_i=0xDDDD..CCCC..BBBB..AAAA (64b each), write_i pulse -> burst_o=0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD.. on successive resp_i, write_o 4 cycles, single resp_o.
REQ-035 Gapped read: resp_i pattern 1,0,0,1,1,0,1 -> correct line, cnt stalls, resp_o only after 4th beat.
REQ-036 read_i=1 and write_i=1 same cycle -> WRITE taken, read_o never asserted; read_i re-pulsed in WRITE -> ignored.
REQ-037 rst=0 asserted between beats 2 and 3 of a read -> read_o drops asynchronously, no resp_o; next read completes normally.
